// File: rtl/si_packet_arbiter_if.sv
// AXI4-Stream bundle shared by the arbiter inputs and its merged output.
// master drives payload and valid; slave drives tready.
interface axis_interface #(
    parameter int DATA_WIDTH = 128
) ();
    localparam int KEEP_W = DATA_WIDTH / 8;

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_W-1:0]     tkeep;
    logic                  tlast;
    logic                  tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/si_packet_arbiter.sv
// Packet-granular round-robin merge of NUM_INPUTS streams; 1-cycle arbitration, 0-cycle passthrough.
// Downstream tready is forwarded only to the granted input; a grant is held until its tlast beat.
module si_packet_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 128,
    localparam int IDX_W = $clog2(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_interface.slave          s_axis [NUM_INPUTS],
    axis_interface.master         m_axis,
    input  logic [NUM_INPUTS-1:0] enable_mask,
    output logic [IDX_W-1:0]      active_port,
    output logic                  busy,
    output logic                  packet_done
);
    localparam int KEEP_W = DATA_WIDTH / 8;

    typedef enum logic {IDLE, GRANT} state_t;

    if (DATA_WIDTH != 128) begin : g_bad_width
        $error("si_packet_arbiter: DATA_WIDTH must be 128");
    end
    if (NUM_INPUTS < 2 || NUM_INPUTS > 16) begin : g_bad_inputs
        $error("si_packet_arbiter: NUM_INPUTS must be 2..16");
    end

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      grant, grant_nxt;
    logic [IDX_W-1:0]      rr_ptr, rr_nxt;
    logic [IDX_W-1:0]      active_nxt;
    logic                  busy_nxt, done_nxt;

    logic [NUM_INPUTS-1:0] in_vld, in_last, in_rdy;
    logic [DATA_WIDTH-1:0] in_dat  [NUM_INPUTS];
    logic [KEEP_W-1:0]     in_keep [NUM_INPUTS];

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_port
        assign in_vld[g]         = s_axis[g].tvalid;
        assign in_dat[g]         = s_axis[g].tdata;
        assign in_keep[g]        = s_axis[g].tkeep;
        assign in_last[g]        = s_axis[g].tlast;
        assign s_axis[g].tready  = in_rdy[g];
    end

    // Cyclic first-set search starting at rr_ptr.
    logic [NUM_INPUTS-1:0] req;
    logic                  req_any;
    logic [IDX_W-1:0]      sel, cand;

    always_comb begin
        req     = in_vld & enable_mask;
        req_any = 1'b0;
        sel     = '0;
        cand    = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_INPUTS);
            if (!req_any && req[cand]) begin
                req_any = 1'b1;
                sel     = cand;
            end
        end
    end

    always_comb begin
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = '0;
        m_axis.tkeep  = '0;
        m_axis.tlast  = 1'b0;
        m_axis.tuser  = 1'b0;
        in_rdy        = '0;
        if (state == GRANT && !rst) begin
            m_axis.tvalid = in_vld[grant];
            m_axis.tdata  = in_dat[grant];
            m_axis.tkeep  = in_keep[grant];
            m_axis.tlast  = in_last[grant];
            in_rdy[grant] = m_axis.tready;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        rr_nxt     = rr_ptr;
        active_nxt = active_port;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_any) begin
                    state_nxt  = GRANT;
                    grant_nxt  = sel;
                    active_nxt = sel;
                    busy_nxt   = 1'b1;
                end
            end
            GRANT: begin
                if (in_vld[grant] && m_axis.tready && in_last[grant]) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    rr_nxt    = (grant == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            active_port <= '0;
            busy        <= 1'b0;
            packet_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            rr_ptr      <= rr_nxt;
            active_port <= active_nxt;
            busy        <= busy_nxt;
            packet_done <= done_nxt;
        end
    end
endmodule
